// File: rtl/rdm_axis_echo_responder.sv
// ============================================================================
// rdm_axis_echo_responder
//
// Far-end peer for the 64-bit RDM network stream. It buffers each request
// packet whole and then replays it as the reply. Beat 0 of the reply has its
// 32-bit halves swapped, which emulates a source/destination header swap.
// Requests longer than MAX_BEATS are discarded. Reception and transmission
// never overlap: the input is held off for the whole time a reply is sent.
//
// Parameters
//   MAX_BEATS      buffer depth in 64-bit beats (>= 2)
//
// Ports
//   clk_390        network clock, rising-edge active
//   sys_rst        asynchronous active-high reset
//   from_net_*     request AXI-Stream slave (tdata/tkeep/tuser/tlast/tvalid/tready)
//   to_net_*       reply AXI-Stream master (tdata/tkeep/tuser/tlast/tvalid/tready)
//   pkt_rx_cnt     packets fully buffered (wraps)
//   pkt_tx_cnt     packets fully sent (wraps)
//   pkt_drop_cnt   oversized packets discarded (wraps)
// ============================================================================
module rdm_axis_echo_responder #(
    parameter int MAX_BEATS = 64
) (
    input  logic        clk_390,
    input  logic        sys_rst,

    input  logic [63:0] from_net_tdata,
    input  logic [7:0]  from_net_tkeep,
    input  logic [63:0] from_net_tuser,
    input  logic        from_net_tlast,
    input  logic        from_net_tvalid,
    output logic        from_net_tready,

    output logic [63:0] to_net_tdata,
    output logic [7:0]  to_net_tkeep,
    output logic [63:0] to_net_tuser,
    output logic        to_net_tlast,
    output logic        to_net_tvalid,
    input  logic        to_net_tready,

    output logic [31:0] pkt_rx_cnt,
    output logic [31:0] pkt_tx_cnt,
    output logic [31:0] pkt_drop_cnt
);

    // Pointers and length must be able to hold MAX_BEATS itself, so they are
    // one bit wider than the buffer address when MAX_BEATS is a power of two.
    localparam int PW = $clog2(MAX_BEATS + 1);
    localparam int AW = $clog2(MAX_BEATS);
    localparam logic [PW-1:0] MAX_P = PW'(MAX_BEATS);
    localparam logic [PW-1:0] ONE_P = PW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Packet storage; contents are don't-care after reset.
    logic [63:0] mem_data [MAX_BEATS];
    logic [7:0]  mem_keep [MAX_BEATS];
    logic [63:0] tuser_q;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] len;

    logic          acc;
    logic          snd;
    logic          room;
    logic          rd_last;
    logic          enter_send;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [63:0]   rd_data;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    assign from_net_tready = !sys_rst && (state != SEND);
    assign acc     = from_net_tvalid && from_net_tready;
    assign snd     = to_net_tvalid && to_net_tready;
    assign room    = (wr_ptr < MAX_P);
    assign rd_last = (rd_ptr == (len - ONE_P));

    // The first beat always lands at address 0, independent of the stale
    // wr_ptr left over from the previous packet.
    assign wr_en   = acc && ((state == IDLE) || ((state == RECV) && room));
    assign wr_addr = (state == IDLE) ? '0 : wr_ptr[AW-1:0];

    assign enter_send = (state != SEND) && (state_nxt == SEND);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_390 or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (acc) begin
                    state_nxt = from_net_tlast ? SEND : RECV;
                end
            end
            RECV: begin
                if (acc) begin
                    if (room) begin
                        if (from_net_tlast) begin
                            state_nxt = SEND;
                        end
                    end else begin
                        // Overflow beat: the packet can no longer be echoed.
                        state_nxt = from_net_tlast ? IDLE : DROP;
                    end
                end
            end
            DROP: begin
                if (acc && from_net_tlast) begin
                    state_nxt = IDLE;
                end
            end
            SEND: begin
                if (snd && rd_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // Everything on to_net_* is forced to zero outside SEND so that reset
    // clears the reply stream at once through the state register.
    // ------------------------------------------------------------------------
    assign rd_data = mem_data[rd_ptr[AW-1:0]];

    always_comb begin
        to_net_tvalid = 1'b0;
        to_net_tdata  = '0;
        to_net_tkeep  = '0;
        to_net_tuser  = '0;
        to_net_tlast  = 1'b0;
        if (state == SEND) begin
            to_net_tvalid = 1'b1;
            to_net_tdata  = (rd_ptr == '0) ? {rd_data[31:0], rd_data[63:32]} : rd_data;
            to_net_tkeep  = mem_keep[rd_ptr[AW-1:0]];
            to_net_tuser  = tuser_q;
            to_net_tlast  = rd_last;
        end
    end

    // ------------------------------------------------------------------------
    // Packet storage and captured sideband (no reset on data)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_390) begin
        if (wr_en) begin
            mem_data[wr_addr] <= from_net_tdata;
            mem_keep[wr_addr] <= from_net_tkeep;
        end
        if (acc && (state == IDLE)) begin
            tuser_q <= from_net_tuser;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers and length
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_390 or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            len    <= '0;
        end else begin
            if (acc && (state == IDLE)) begin
                wr_ptr <= ONE_P;
                if (from_net_tlast) begin
                    len <= ONE_P;
                end
            end else if (acc && (state == RECV) && room) begin
                wr_ptr <= wr_ptr + ONE_P;
                if (from_net_tlast) begin
                    len <= wr_ptr + ONE_P;
                end
            end

            if (enter_send) begin
                rd_ptr <= '0;
            end else if (snd) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Status counters (free-running, wrap at 2^32)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_390 or posedge sys_rst) begin
        if (sys_rst) begin
            pkt_rx_cnt   <= '0;
            pkt_tx_cnt   <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            if (enter_send) begin
                pkt_rx_cnt <= pkt_rx_cnt + 32'd1;
            end
            if (snd && rd_last) begin
                pkt_tx_cnt <= pkt_tx_cnt + 32'd1;
            end
            if (acc && from_net_tlast &&
                (((state == RECV) && !room) || (state == DROP))) begin
                pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_rdm_axis_echo_responder.sv
module tb_rdm_axis_echo_responder;

    localparam int MB = 4;

    logic        clk_390 = 1'b0;
    logic        sys_rst;
    logic [63:0] from_net_tdata;
    logic [7:0]  from_net_tkeep;
    logic [63:0] from_net_tuser;
    logic        from_net_tlast;
    logic        from_net_tvalid;
    logic        from_net_tready;
    logic [63:0] to_net_tdata;
    logic [7:0]  to_net_tkeep;
    logic [63:0] to_net_tuser;
    logic        to_net_tlast;
    logic        to_net_tvalid;
    logic        to_net_tready;
    logic [31:0] pkt_rx_cnt;
    logic [31:0] pkt_tx_cnt;
    logic [31:0] pkt_drop_cnt;

    rdm_axis_echo_responder #(.MAX_BEATS(MB)) dut (
        .clk_390         (clk_390),
        .sys_rst         (sys_rst),
        .from_net_tdata  (from_net_tdata),
        .from_net_tkeep  (from_net_tkeep),
        .from_net_tuser  (from_net_tuser),
        .from_net_tlast  (from_net_tlast),
        .from_net_tvalid (from_net_tvalid),
        .from_net_tready (from_net_tready),
        .to_net_tdata    (to_net_tdata),
        .to_net_tkeep    (to_net_tkeep),
        .to_net_tuser    (to_net_tuser),
        .to_net_tlast    (to_net_tlast),
        .to_net_tvalid   (to_net_tvalid),
        .to_net_tready   (to_net_tready),
        .pkt_rx_cnt      (pkt_rx_cnt),
        .pkt_tx_cnt      (pkt_tx_cnt),
        .pkt_drop_cnt    (pkt_drop_cnt)
    );

    always #5 clk_390 = ~clk_390;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic [63:0] u;
        logic        l;
    } beat_t;

    beat_t q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_tx_edge = 0;
    int first_acc_edge = 0;

    always @(posedge clk_390) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reply monitor: pops the scoreboard on each handshake, checks hold
    // stability across stalls, and checks that input and output never overlap.
    logic  prev_stall = 1'b0;
    beat_t prev_b;
    always @(negedge clk_390) begin
        beat_t cur;
        beat_t e;
        cur = {to_net_tdata, to_net_tkeep, to_net_tuser, to_net_tlast};
        if (!sys_rst) chk("ready_vs_valid", 64'(from_net_tready), 64'(!to_net_tvalid));
        if (!sys_rst && to_net_tvalid) begin
            if (prev_stall) begin
                chk("stall_data", cur.d, prev_b.d);
                chk("stall_user", cur.u, prev_b.u);
                chk("stall_keep_last", 64'({cur.k, cur.l}), 64'({prev_b.k, prev_b.l}));
            end
            if (to_net_tready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat_valid", 64'(to_net_tvalid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("reply_data", cur.d, e.d);
                    chk("reply_keep", 64'(cur.k), 64'(e.k));
                    chk("reply_user", cur.u, e.u);
                    chk("reply_last", 64'(cur.l), 64'(e.l));
                    if (e.l) last_tx_edge = cyc + 1;
                end
            end
            prev_stall = !to_net_tready;
            prev_b = cur;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_pkt(input int n, input logic [63:0] user, input bit echo,
                            input logic [63:0] d0);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            int t;
            from_net_tvalid = 1'b1;
            from_net_tdata  = (i == 0) ? d0 : {$urandom, $urandom};
            from_net_tkeep  = (i == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            from_net_tuser  = (i == 0) ? user : {$urandom, $urandom};
            from_net_tlast  = (i == n - 1);
            t = 0;
            while (!from_net_tready && t < 300) begin
                @(posedge clk_390); #1;
                t++;
            end
            chk("accept_wait", 64'(from_net_tready), 64'd1);
            if (i == 0) first_acc_edge = cyc + 1;
            if (echo) begin
                b.d = (i == 0) ? {from_net_tdata[31:0], from_net_tdata[63:32]} : from_net_tdata;
                b.k = from_net_tkeep;
                b.u = user;
                b.l = (i == n - 1);
                q.push_back(b);
            end
            @(posedge clk_390); #1;
        end
        from_net_tvalid = 1'b0;
        from_net_tlast  = 1'b0;
        chk("reply_latency", 64'(to_net_tvalid), 64'(echo));
    endtask

    task automatic drain(input logic [2:0] pat);
        int k;
        k = 0;
        while (k < 300) begin
            to_net_tready = pat[k % 3];
            @(posedge clk_390); #1;
            k++;
            if (q.size() == 0 && !to_net_tvalid) break;
        end
        chk("drain_done", 64'(q.size()), 64'd0);
        to_net_tready = 1'b1;
    endtask

    task automatic chk_cnt(input int rx, input int tx, input int drop);
        chk("pkt_rx_cnt", 64'(pkt_rx_cnt), 64'(rx));
        chk("pkt_tx_cnt", 64'(pkt_tx_cnt), 64'(tx));
        chk("pkt_drop_cnt", 64'(pkt_drop_cnt), 64'(drop));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst         = 1'b1;
        from_net_tdata  = '0;
        from_net_tkeep  = '0;
        from_net_tuser  = '0;
        from_net_tlast  = 1'b0;
        from_net_tvalid = 1'b0;
        to_net_tready   = 1'b1;

        // Reset state
        repeat (3) @(posedge clk_390);
        #1;
        chk("rst_tvalid", 64'(to_net_tvalid), 64'd0);
        chk("rst_tdata", to_net_tdata, 64'd0);
        chk("rst_tkeep_last", 64'({to_net_tkeep, to_net_tlast}), 64'd0);
        chk("rst_tuser", to_net_tuser, 64'd0);
        chk("rst_from_tready", 64'(from_net_tready), 64'd0);
        chk_cnt(0, 0, 0);
        sys_rst = 1'b0;
        #1;
        chk("post_rst_from_tready", 64'(from_net_tready), 64'd1);

        // Single-beat packet
        @(posedge clk_390); #1;
        send_pkt(1, 64'hA5A5_0001_DEAD_BEEF, 1'b1, 64'h1122334455667788);
        chk("single_swap_data", to_net_tdata, 64'h5566778811223344);
        chk("single_tlast", 64'(to_net_tlast), 64'd1);
        drain(3'b111);
        chk_cnt(1, 1, 0);

        // 3-beat packet with tready 1,0,0,...
        send_pkt(3, 64'h0123_4567_89AB_CDEF, 1'b1, {$urandom, $urandom});
        drain(3'b001);
        chk_cnt(2, 2, 0);

        // Oversized packet dropped, then a 2-beat packet echoed
        send_pkt(6, 64'h6666_0000_6666_0000, 1'b0, {$urandom, $urandom});
        chk_cnt(2, 2, 1);
        send_pkt(2, 64'h2222_1111_2222_1111, 1'b1, {$urandom, $urandom});
        drain(3'b111);
        chk_cnt(3, 3, 1);

        // Exactly MAX_BEATS beats
        send_pkt(MB, 64'h4444_4444_0000_0004, 1'b1, {$urandom, $urandom});
        drain(3'b011);
        chk_cnt(4, 4, 1);

        // Back-to-back requests
        to_net_tready = 1'b1;
        send_pkt(2, 64'hB2B0_0000_0000_0001, 1'b1, {$urandom, $urandom});
        send_pkt(3, 64'hB2B0_0000_0000_0002, 1'b1, {$urandom, $urandom});
        chk("b2b_turnaround", 64'(first_acc_edge), 64'(last_tx_edge + 1));
        drain(3'b111);
        chk_cnt(6, 6, 1);

        // Reset during beat 2 of a 4-beat reply
        to_net_tready = 1'b1;
        send_pkt(4, 64'hFEED_0000_0000_0004, 1'b1, {$urandom, $urandom});
        begin
            int t;
            t = 0;
            while (q.size() > 2 && t < 50) begin
                @(posedge clk_390); #1;
                t++;
            end
        end
        chk("mid_send_remaining", 64'(q.size()), 64'd2);
        chk("mid_send_valid", 64'(to_net_tvalid), 64'd1);
        sys_rst = 1'b1;
        #1;
        chk("rst_send_tvalid", 64'(to_net_tvalid), 64'd0);
        chk("rst_send_tdata", to_net_tdata, 64'd0);
        chk("rst_send_tuser", to_net_tuser, 64'd0);
        chk("rst_send_keep_last", 64'({to_net_tkeep, to_net_tlast}), 64'd0);
        chk("rst_send_from_tready", 64'(from_net_tready), 64'd0);
        chk_cnt(0, 0, 0);
        q.delete();
        repeat (2) @(posedge clk_390);
        #1;
        sys_rst = 1'b0;
        @(posedge clk_390); #1;
        send_pkt(1, 64'h0000_0000_FFFF_FFFF, 1'b1, 64'h0F0F_0F0F_F0F0_F0F0);
        drain(3'b111);
        chk_cnt(1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
